// File: rtl/powlib_cntr.sv
// Parameterised synchronous up/down counter used as FIFO pointer and occupancy primitive.
// Advances by a fixed step X or a signed per-cycle delta dx; supports clear and optional load.
module powlib_cntr #(
    parameter int             W    = 16,
    parameter logic [W-1:0]   X    = 1,
    parameter logic [W-1:0]   INIT = 0,
    parameter bit             ELD  = 1'b1,
    parameter bit             EDX  = 1'b0,
    parameter bit             EAR  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cntr,
    input  logic         adv,
    input  logic [W-1:0] dx,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] nval
);

    logic [W-1:0] step;

    // EAR is accepted only so older instantiations still elaborate; reset is always synchronous.
    if (EAR) begin : g_ear_ignored
    end

    assign step = EDX ? dx : X;

    always_ff @(posedge clk) begin
        if (rst) begin
            cntr <= INIT;
        end else if (clr) begin
            cntr <= INIT;
        end else if (ELD && ld) begin
            cntr <= nval;
        end else if (adv) begin
            // Modulo-2^W add: dx of all-ones decrements, dx of zero holds.
            cntr <= cntr + step;
        end
    end

endmodule

// File: tb/tb_powlib_cntr.sv
// Directed self-checking bench for powlib_cntr across several parameterisations.
// Each instance owns its control inputs; reset is shared.
module tb_powlib_cntr;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // a: W=4 INIT=5 (reset, mid-operation reset)
    logic [3:0] cntr_a, dx_a, nval_a;
    logic       adv_a, clr_a, ld_a;
    // b: W=3 INIT=0 X=1 (wrap, clear priority)
    logic [2:0] cntr_b, dx_b, nval_b;
    logic       adv_b, clr_b, ld_b;
    // c: W=3 INIT=1 (clear priority with non-zero INIT)
    logic [2:0] cntr_c, dx_c, nval_c;
    logic       adv_c, clr_c, ld_c;
    // d: W=3 EDX=1 (delta mode)
    logic [2:0] cntr_d, dx_d, nval_d;
    logic       adv_d, clr_d, ld_d;
    // e: W=8 ELD=1 INIT=3 (load path)
    logic [7:0] cntr_e, dx_e, nval_e;
    logic       adv_e, clr_e, ld_e;
    // f: W=8 ELD=0 (load path disabled)
    logic [7:0] cntr_f, dx_f, nval_f;
    logic       adv_f, clr_f, ld_f;

    powlib_cntr #(.W(4), .X(4'd1), .INIT(4'd5), .ELD(1'b1), .EDX(1'b0), .EAR(1'b0)) u_a (
        .clk(clk), .rst(rst), .cntr(cntr_a), .adv(adv_a), .dx(dx_a),
        .clr(clr_a), .ld(ld_a), .nval(nval_a));
    powlib_cntr #(.W(3), .X(3'd1), .INIT(3'd0), .ELD(1'b1), .EDX(1'b0), .EAR(1'b0)) u_b (
        .clk(clk), .rst(rst), .cntr(cntr_b), .adv(adv_b), .dx(dx_b),
        .clr(clr_b), .ld(ld_b), .nval(nval_b));
    powlib_cntr #(.W(3), .X(3'd1), .INIT(3'd1), .ELD(1'b1), .EDX(1'b0), .EAR(1'b0)) u_c (
        .clk(clk), .rst(rst), .cntr(cntr_c), .adv(adv_c), .dx(dx_c),
        .clr(clr_c), .ld(ld_c), .nval(nval_c));
    powlib_cntr #(.W(3), .X(3'd1), .INIT(3'd0), .ELD(1'b1), .EDX(1'b1), .EAR(1'b0)) u_d (
        .clk(clk), .rst(rst), .cntr(cntr_d), .adv(adv_d), .dx(dx_d),
        .clr(clr_d), .ld(ld_d), .nval(nval_d));
    powlib_cntr #(.W(8), .X(8'd1), .INIT(8'd3), .ELD(1'b1), .EDX(1'b0), .EAR(1'b0)) u_e (
        .clk(clk), .rst(rst), .cntr(cntr_e), .adv(adv_e), .dx(dx_e),
        .clr(clr_e), .ld(ld_e), .nval(nval_e));
    powlib_cntr #(.W(8), .X(8'd1), .INIT(8'd0), .ELD(1'b0), .EDX(1'b0), .EAR(1'b1)) u_f (
        .clk(clk), .rst(rst), .cntr(cntr_f), .adv(adv_f), .dx(dx_f),
        .clr(clr_f), .ld(ld_f), .nval(nval_f));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {adv_a, clr_a, ld_a} = '0; dx_a = '0; nval_a = '0;
        {adv_b, clr_b, ld_b} = '0; dx_b = '0; nval_b = '0;
        {adv_c, clr_c, ld_c} = '0; dx_c = '0; nval_c = '0;
        {adv_d, clr_d, ld_d} = '0; dx_d = '0; nval_d = '0;
        {adv_e, clr_e, ld_e} = '0; dx_e = '0; nval_e = '0;
        {adv_f, clr_f, ld_f} = '0; dx_f = '0; nval_f = '0;

        // Reset held two cycles with adv=1 on a
        adv_a = 1'b1;
        tick();
        check("rst_a_c1", {4'd0, cntr_a}, 8'd5);
        tick();
        check("rst_a_c2", {4'd0, cntr_a}, 8'd5);
        check("rst_b", {5'd0, cntr_b}, 8'd0);
        check("rst_c", {5'd0, cntr_c}, 8'd1);
        check("rst_e", cntr_e, 8'd3);
        rst = 1'b0;
        tick();
        check("a_inc6", {4'd0, cntr_a}, 8'd6);
        tick();
        check("a_inc7", {4'd0, cntr_a}, 8'd7);
        tick();
        check("a_inc8", {4'd0, cntr_a}, 8'd8);
        tick();
        check("a_inc9", {4'd0, cntr_a}, 8'd9);

        // Mid-operation reset overrides ld and adv
        rst = 1'b1; ld_a = 1'b1; nval_a = 4'd12;
        tick();
        check("a_midrst", {4'd0, cntr_a}, 8'd5);
        rst = 1'b0; ld_a = 1'b0;
        tick();
        check("a_resume", {4'd0, cntr_a}, 8'd6);
        adv_a = 1'b0;

        // Wrap on b; dx must be ignored with EDX=0
        dx_b = 3'd5;
        for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i % 8));
        adv_b = 1'b1;
        while (exp_q.size() > 0) begin
            tick();
            check("b_wrap", {5'd0, cntr_b}, exp_q.pop_front());
        end
        adv_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_hold", {5'd0, cntr_b}, 8'd1);
        end

        // Clear beats advance, INIT=0
        adv_b = 1'b1;
        tick(); tick(); tick();
        check("b_at4", {5'd0, cntr_b}, 8'd4);
        clr_b = 1'b1;
        tick();
        check("b_clr_adv", {5'd0, cntr_b}, 8'd0);
        clr_b = 1'b0; adv_b = 1'b0;

        // Clear beats advance, INIT=1
        adv_c = 1'b1;
        tick(); tick(); tick();
        check("c_at4", {5'd0, cntr_c}, 8'd4);
        clr_c = 1'b1;
        tick();
        check("c_clr_adv", {5'd0, cntr_c}, 8'd1);
        clr_c = 1'b0; adv_c = 1'b0;

        // Delta mode
        adv_d = 1'b1; dx_d = 3'd1;
        tick();
        check("d_up1", {5'd0, cntr_d}, 8'd1);
        tick();
        check("d_up2", {5'd0, cntr_d}, 8'd2);
        dx_d = 3'd7;
        tick();
        check("d_dn1", {5'd0, cntr_d}, 8'd1);
        tick();
        check("d_dn0", {5'd0, cntr_d}, 8'd0);
        tick();
        check("d_dn_wrap", {5'd0, cntr_d}, 8'd7);
        dx_d = 3'd0;
        tick();
        check("d_dx0", {5'd0, cntr_d}, 8'd7);
        adv_d = 1'b0; dx_d = 3'd1;
        tick();
        check("d_noadv", {5'd0, cntr_d}, 8'd7);

        // Load path enabled
        ld_e = 1'b1; nval_e = 8'd10;
        tick();
        check("e_ld10", cntr_e, 8'd10);
        nval_e = 8'd200; adv_e = 1'b1;
        tick();
        check("e_ld_adv", cntr_e, 8'd200);
        clr_e = 1'b1;
        tick();
        check("e_clr_ld", cntr_e, 8'd3);
        clr_e = 1'b0; ld_e = 1'b0;
        tick();
        check("e_adv", cntr_e, 8'd4);
        adv_e = 1'b0;

        // Load path disabled
        adv_f = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("f_at10", cntr_f, 8'd10);
        ld_f = 1'b1; nval_f = 8'd200;
        tick();
        check("f_ld_ignored_adv", cntr_f, 8'd11);
        adv_f = 1'b0;
        tick();
        check("f_ld_ignored_hold", cntr_f, 8'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
